// File: rtl/mp_fifo_dat_vld_output_pkg.sv
// Shared sizing helpers and pointer wrap arithmetic for the multi-port data/valid-output FIFO.
package mp_fifo_dat_vld_output_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Operands are always below depth, so one compare-subtract wraps correctly for any depth.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned depth);
    int unsigned s;
    s = a + b;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/mp_fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping with prefix-masked enqueue/dequeue handshakes and synchronous flush.
module mp_fifo_ptr_ctrl
  import mp_fifo_dat_vld_output_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ENQ_WIDTH      = 2,
  parameter int unsigned DEQ_WIDTH      = 2,
  parameter int unsigned MUST_TAKEN_ALL = 1,
  localparam int unsigned PW            = ptr_w(DEPTH),
  localparam int unsigned CW            = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [ENQ_WIDTH-1:0] enq_vld_i,
  input  logic [DEQ_WIDTH-1:0] deq_rdy_i,
  output logic [ENQ_WIDTH-1:0] enq_rdy_o,
  output logic [DEQ_WIDTH-1:0] deq_vld_o,
  output logic [ENQ_WIDTH-1:0] enq_fire_o,
  output logic [DEQ_WIDTH-1:0] deq_fire_o,
  output logic [PW-1:0]        head_o,
  output logic [PW-1:0]        tail_o,
  output logic [CW-1:0]        count_o
);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  int unsigned   cnt_u, avail, n_enq, n_deq;
  logic          enq_run, deq_run;

  // Readiness comes from the registered count only: a same-cycle dequeue frees nothing.
  always_comb begin
    cnt_u      = 32'(count);
    avail      = DEPTH - cnt_u;
    enq_rdy_o  = '0;
    enq_fire_o = '0;
    n_enq      = 0;
    enq_run    = 1'b1;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      if (!flush_i)
        enq_rdy_o[i] = (MUST_TAKEN_ALL != 0) ? (avail >= ENQ_WIDTH) : (avail > i);
      enq_fire_o[i] = enq_run & enq_vld_i[i] & enq_rdy_o[i];
      enq_run       = enq_fire_o[i];
      if (enq_fire_o[i]) n_enq = n_enq + 1;
    end
    deq_vld_o  = '0;
    deq_fire_o = '0;
    n_deq      = 0;
    deq_run    = 1'b1;
    for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
      if (!flush_i) deq_vld_o[i] = (cnt_u > i);
      deq_fire_o[i] = deq_run & deq_rdy_i[i] & deq_vld_o[i];
      deq_run       = deq_fire_o[i];
      if (deq_fire_o[i]) n_deq = n_deq + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= PW'(mod_add(32'(head), n_deq, DEPTH));
      tail  <= PW'(mod_add(32'(tail), n_enq, DEPTH));
      count <= CW'(cnt_u + n_enq - n_deq);
    end
  end

  assign head_o  = head;
  assign tail_o  = tail;
  assign count_o = count;

endmodule

// File: rtl/mp_fifo_dat_vld_output.sv
// Multi-port in-order FIFO exposing its raw storage array and per-entry live bits for snooping.
module mp_fifo_dat_vld_output
  import mp_fifo_dat_vld_output_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH  = 8,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ENQ_WIDTH      = 2,
  parameter int unsigned DEQ_WIDTH      = 2,
  parameter int unsigned MUST_TAKEN_ALL = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [ENQ_WIDTH-1:0]               enqueue_vld_i,
  input  logic [ENQ_WIDTH*PAYLOAD_WIDTH-1:0] enqueue_payload_i,
  output logic [ENQ_WIDTH-1:0]               enqueue_rdy_o,
  output logic [DEQ_WIDTH-1:0]               dequeue_vld_o,
  output logic [DEQ_WIDTH*PAYLOAD_WIDTH-1:0] dequeue_payload_o,
  input  logic [DEQ_WIDTH-1:0]               dequeue_rdy_i,
  output logic [DEPTH*PAYLOAD_WIDTH-1:0]     payload_dff,
  output logic [DEPTH-1:0]                   payload_vld_dff,
  output logic [cnt_w(DEPTH)-1:0]            occupancy_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0]            head, tail;
  logic [ENQ_WIDTH-1:0]     enq_fire;
  logic [DEQ_WIDTH-1:0]     deq_fire;
  logic [PW-1:0]            enq_idx [ENQ_WIDTH];
  logic [PW-1:0]            deq_idx [DEQ_WIDTH];
  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]         vld_q, vld_n;

  mp_fifo_ptr_ctrl #(
    .DEPTH          (DEPTH),
    .ENQ_WIDTH      (ENQ_WIDTH),
    .DEQ_WIDTH      (DEQ_WIDTH),
    .MUST_TAKEN_ALL (MUST_TAKEN_ALL)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .enq_vld_i  (enqueue_vld_i),
    .deq_rdy_i  (dequeue_rdy_i),
    .enq_rdy_o  (enqueue_rdy_o),
    .deq_vld_o  (dequeue_vld_o),
    .enq_fire_o (enq_fire),
    .deq_fire_o (deq_fire),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (occupancy_o)
  );

  always_comb begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      enq_idx[i] = PW'(mod_add(32'(tail), i, DEPTH));
    for (int unsigned i = 0; i < DEQ_WIDTH; i++)
      deq_idx[i] = PW'(mod_add(32'(head), i, DEPTH));
  end

  // Enqueue targets never overlap same-cycle dequeue targets, so set/clear order is irrelevant.
  always_comb begin
    vld_n = vld_q;
    for (int unsigned i = 0; i < DEQ_WIDTH; i++)
      if (deq_fire[i]) vld_n[deq_idx[i]] = 1'b0;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      if (enq_fire[i]) vld_n[enq_idx[i]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) vld_q <= '0;
    else                vld_q <= vld_n;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++)
      if (enq_fire[i]) mem[enq_idx[i]] <= enqueue_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++)
      payload_dff[e*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[e];
    for (int unsigned i = 0; i < DEQ_WIDTH; i++)
      dequeue_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[deq_idx[i]];
  end

  assign payload_vld_dff = vld_q;

endmodule

// File: tb/tb_mp_fifo_dat_vld_output.sv
// Directed plus random bench for two DEPTH=6 FIFOs (all-or-none and per-lane readiness).
module tb_mp_fifo_dat_vld_output;

  localparam int unsigned W = 8;
  localparam int unsigned D = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush   [2];
  logic [1:0]   enq_vld [2];
  logic [15:0]  enq_pl  [2];
  logic [1:0]   enq_rdy [2];
  logic [1:0]   deq_vld [2];
  logic [15:0]  deq_pl  [2];
  logic [1:0]   deq_rdy [2];
  logic [47:0]  pd      [2];
  logic [5:0]   pv      [2];
  logic [2:0]   occ     [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: FIFO contents described by first index and length over a shadow array.
  int unsigned m_head [2];
  int unsigned m_cnt  [2];
  logic [7:0]  m_mem  [2][6];
  logic [5:0]  m_known[2];

  always #5 clk = ~clk;

  mp_fifo_dat_vld_output #(.PAYLOAD_WIDTH(W), .DEPTH(D), .ENQ_WIDTH(2), .DEQ_WIDTH(2),
                           .MUST_TAKEN_ALL(1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush[0]), .enqueue_vld_i(enq_vld[0]),
    .enqueue_payload_i(enq_pl[0]), .enqueue_rdy_o(enq_rdy[0]), .dequeue_vld_o(deq_vld[0]),
    .dequeue_payload_o(deq_pl[0]), .dequeue_rdy_i(deq_rdy[0]), .payload_dff(pd[0]),
    .payload_vld_dff(pv[0]), .occupancy_o(occ[0]));

  mp_fifo_dat_vld_output #(.PAYLOAD_WIDTH(W), .DEPTH(D), .ENQ_WIDTH(2), .DEQ_WIDTH(2),
                           .MUST_TAKEN_ALL(0)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush[1]), .enqueue_vld_i(enq_vld[1]),
    .enqueue_payload_i(enq_pl[1]), .enqueue_rdy_o(enq_rdy[1]), .dequeue_vld_o(deq_vld[1]),
    .dequeue_payload_o(deq_pl[1]), .dequeue_rdy_i(deq_rdy[1]), .payload_dff(pd[1]),
    .payload_vld_dff(pv[1]), .occupancy_o(occ[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input int u);
    logic [5:0] exp_v;
    for (int e = 0; e < 6; e++)
      exp_v[e] = (((e + 6 - int'(m_head[u])) % 6) < int'(m_cnt[u]));
    chk($sformatf("occupancy%0d", u), 64'(occ[u]), 64'(m_cnt[u]));
    chk($sformatf("payload_vld_dff%0d", u), 64'(pv[u]), 64'(exp_v));
    for (int e = 0; e < 6; e++)
      if (m_known[u][e])
        chk($sformatf("payload_dff%0d[%0d]", u, e), 64'(pd[u][e*8 +: 8]), 64'(m_mem[u][e]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      flush[u] = 1'b0; enq_vld[u] = '0; enq_pl[u] = '0; deq_rdy[u] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_head[u] = 0; m_cnt[u] = 0;
      check_state(u);
    end
  endtask

  // One clock on instance u: check handshake outputs mid-cycle, then advance model and check state.
  task automatic cycle(input int u, input logic [1:0] ev, input logic [7:0] p0,
                       input logic [7:0] p1, input logic [1:0] dr, input logic fl);
    logic [1:0]  erdy, dvld;
    int unsigned avail, ne, nd;
    logic [7:0]  pl [2];
    pl[0] = p0; pl[1] = p1;
    enq_vld[u] = ev; enq_pl[u] = {p1, p0}; deq_rdy[u] = dr; flush[u] = fl;
    @(negedge clk);
    avail = 6 - m_cnt[u];
    if (fl)          erdy = 2'b00;
    else if (u == 0) erdy = (avail >= 2) ? 2'b11 : 2'b00;
    else             erdy = {avail > 1, avail > 0};
    dvld = fl ? 2'b00 : {m_cnt[u] > 1, m_cnt[u] > 0};
    chk($sformatf("enqueue_rdy%0d", u), 64'(enq_rdy[u]), 64'(erdy));
    chk($sformatf("dequeue_vld%0d", u), 64'(deq_vld[u]), 64'(dvld));
    for (int i = 0; i < 2; i++)
      if (dvld[i])
        chk($sformatf("dequeue_payload%0d[%0d]", u, i), 64'(deq_pl[u][i*8 +: 8]),
            64'(m_mem[u][(m_head[u] + i) % 6]));
    ne = 0;
    while (ne < 2 && ev[ne] && erdy[ne]) ne++;
    nd = 0;
    while (nd < 2 && dr[nd] && dvld[nd]) nd++;
    @(posedge clk); #1;
    if (fl) begin
      m_head[u] = 0; m_cnt[u] = 0;
    end else begin
      for (int unsigned k = 0; k < ne; k++) begin
        m_mem[u][(m_head[u] + m_cnt[u] + k) % 6]   = pl[k];
        m_known[u][(m_head[u] + m_cnt[u] + k) % 6] = 1'b1;
      end
      m_head[u] = (m_head[u] + nd) % 6;
      m_cnt[u]  = m_cnt[u] + ne - nd;
    end
    check_state(u);
    enq_vld[u] = '0; deq_rdy[u] = '0; flush[u] = 1'b0;
  endtask

  initial begin
    m_known[0] = '0; m_known[1] = '0;
    do_reset();
    cycle(0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);

    // fill to full with pairs, then drain in order
    cycle(0, 2'b11, 8'h10, 8'h11, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h12, 8'h13, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h14, 8'h15, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'hee, 8'hef, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 8'h00, 8'h00, 2'b11, 1'b0);

    // wrap: push 5, pop 4, push 4 -> entries 5,0,1,2
    cycle(0, 2'b11, 8'h20, 8'h21, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h22, 8'h23, 2'b00, 1'b0);
    cycle(0, 2'b01, 8'h24, 8'h00, 2'b00, 1'b0);
    cycle(0, 2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    cycle(0, 2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    cycle(0, 2'b11, 8'h25, 8'h26, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h27, 8'h28, 2'b00, 1'b0);

    // count=5: no enqueue credit from the concurrent dequeue
    cycle(0, 2'b11, 8'h30, 8'h31, 2'b11, 1'b0);
    // prefix holes: nothing fires
    cycle(0, 2'b10, 8'h32, 8'h33, 2'b10, 1'b0);
    // count=4, then flush with concurrent requests, then enqueue lands at entry 0
    cycle(0, 2'b01, 8'h34, 8'h00, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h40, 8'h41, 2'b11, 1'b1);
    cycle(0, 2'b11, 8'h50, 8'h51, 2'b00, 1'b0);

    // per-lane readiness near full
    cycle(1, 2'b11, 8'h60, 8'h61, 2'b00, 1'b0);
    cycle(1, 2'b11, 8'h62, 8'h63, 2'b00, 1'b0);
    cycle(1, 2'b01, 8'h64, 8'h00, 2'b00, 1'b0);
    cycle(1, 2'b11, 8'h65, 8'h66, 2'b00, 1'b0);
    cycle(1, 2'b11, 8'h67, 8'h68, 2'b00, 1'b0);

    // reset while full
    do_reset();
    cycle(1, 2'b11, 8'h70, 8'h71, 2'b00, 1'b0);
    cycle(0, 2'b11, 8'h72, 8'h73, 2'b00, 1'b0);

    for (int i = 0; i < 400; i++)
      cycle(i % 2, 2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
            ($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
